// File: rtl/updown_counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
// The optional step feature is controlled by UPDOWN_COUNTER_STEP_EN.
package updown_counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Largest value representable in 'width' bits.
  function automatic longint unsigned default_max_val(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/updown_counter_n_if.sv
// Control/status bundle for updown_counter_n.
// The step signal exists only when UPDOWN_COUNTER_STEP_EN is defined.
interface updown_counter_n_if #(
  parameter int unsigned WIDTH = 8
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             count;
  logic             inc;
  logic             sat;
`ifdef UPDOWN_COUNTER_STEP_EN
  logic [WIDTH-1:0] step;
`endif
  logic [WIDTH-1:0] q;
  logic             cout;
  logic             zero;
  logic             max;

  modport master (
    output clr, load, load_val, count, inc, sat,
`ifdef UPDOWN_COUNTER_STEP_EN
    output step,
`endif
    input  q, cout, zero, max
  );

  modport slave (
    input  clr, load, load_val, count, inc, sat,
`ifdef UPDOWN_COUNTER_STEP_EN
    input  step,
`endif
    output q, cout, zero, max
  );
endinterface

// File: rtl/updown_counter_next.sv
// Combinational next-value and terminal-condition logic for the up/down counter.
// All arithmetic is one bit wider than q so MAX_VAL = 2**WIDTH-1 cannot overflow.
module updown_counter_next
  import updown_counter_pkg::*;
#(
  parameter int unsigned     WIDTH   = 8,
  parameter longint unsigned MAX_VAL = default_max_val(WIDTH)
) (
  input  logic [WIDTH-1:0] q,
  input  logic             inc,
  input  logic             sat,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] q_next,
  output logic             term
);

  localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] MOD_W = MAX_W + {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] q_w;
  logic [WIDTH:0] step_w;
  logic [WIDTH:0] sum_w;
  logic [WIDTH:0] res_w;

  // Step clamp, boundary detection and wrap/saturate resolution.
  always_comb begin
    q_w    = {1'b0, q};
    step_w = ({1'b0, step} > MAX_W) ? MAX_W : {1'b0, step};
    sum_w  = q_w + step_w;
    res_w  = q_w;
    term   = 1'b0;
    if (inc == DIR_UP) begin
      term = (sum_w > MAX_W);
      if (!term) begin
        res_w = sum_w;
      end else if (sat == MODE_SAT) begin
        res_w = MAX_W;
      end else begin
        res_w = sum_w - MOD_W;
      end
    end else begin
      term = (step_w > q_w);
      if (!term) begin
        res_w = q_w - step_w;
      end else if (sat == MODE_SAT) begin
        res_w = {(WIDTH+1){1'b0}};
      end else begin
        res_w = q_w + MOD_W - step_w;
      end
    end
    q_next = WIDTH'(res_w);
  end

endmodule

// File: rtl/updown_counter_n.sv
// Parametrised up/down counter with clear, clamped load, wrap/saturate and cascade carry.
// Define UPDOWN_COUNTER_STEP_EN to add a per-edge step input; otherwise the step is 1.
module updown_counter_n
  import updown_counter_pkg::*;
#(
  parameter int unsigned     WIDTH   = 8,
  parameter longint unsigned MAX_VAL = default_max_val(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_,
  updown_counter_n_if.slave bus
);

  localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] q_next_s;
  logic [WIDTH-1:0] load_clamp_s;
  logic [WIDTH-1:0] step_s;
  logic             term_s;

`ifdef UPDOWN_COUNTER_STEP_EN
  assign step_s = bus.step;
`else
  assign step_s = {{(WIDTH-1){1'b0}}, 1'b1};
`endif

  updown_counter_next #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .q      (cnt_q),
    .inc    (bus.inc),
    .sat    (bus.sat),
    .step   (step_s),
    .q_next (q_next_s),
    .term   (term_s)
  );

  assign load_clamp_s = ({1'b0, bus.load_val} > MAX_W) ? MAX_Q : bus.load_val;

  // Edge priority: clear, then load, then count, else hold.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.clr) begin
      cnt_d = {WIDTH{1'b0}};
    end else if (bus.load) begin
      cnt_d = load_clamp_s;
    end else if (bus.count) begin
      cnt_d = q_next_s;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      cnt_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.q    = cnt_q;
  assign bus.zero = (cnt_q == {WIDTH{1'b0}});
  assign bus.max  = (cnt_q == MAX_Q);
  // Carry is only meaningful when this edge will actually count.
  assign bus.cout = reset_ & bus.count & ~bus.clr & ~bus.load & term_s;

endmodule

// File: doc/updown_counter_n.md
Name: updown_counter_n

Overview:
Parametrised synchronous up/down counter. It is the successor to the fixed 3-bit gate-level counter.
- Width and modulus are set by parameters.
- Adds synchronous clear, parallel load, and selectable wrap or saturate mode.
- Provides a cascadable carry/borrow output (cout) so wider counters can be chained, with zero/max status flags.
- Used for event counting, decade/BCD-style dividers and timer prescalers.

Parameters:
- WIDTH, 8, counter width in bits (>=2).
- MAX_VAL, (2**WIDTH)-1, terminal value. Count range is 0..MAX_VAL. Must be <= 2**WIDTH-1.

Ports:
- clk  in  1  clock, rising-edge.
- reset_  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value for load.
- count  in  1  count enable (cascade input, same role as a lower stage's cout).
- inc  in  1  direction: 1 = up, 0 = down.
- sat  in  1  mode: 1 = saturate at bounds, 0 = wrap.
- q  out  WIDTH  counter value.
- cout  out  1  combinational carry/borrow, for cascading.
- zero  out  1  q == 0.
- max  out  1  q == MAX_VAL.

Behaviour:
- Reset: reset_ low forces q=0 immediately, independent of clk. Outputs during reset: zero=1, max=0 (max=1 only if MAX_VAL==0, which is illegal), cout=0 while reset_ is low.
- Reset release: first counting edge is the first rising clk with reset_ high.
- Priority on each rising edge: clr > load > count > hold.
- clr=1: q<=0. Overrides load and count.
- load=1 (clr=0): q<=load_val. If load_val > MAX_VAL, q<=MAX_VAL (clamped).
- count=1, inc=1, up:
  - q<MAX_VAL: q<=q+1.
  - q==MAX_VAL: wrap mode (sat=0) gives q<=0; saturate mode (sat=1) holds q.
- count=1, inc=0, down:
  - q>0: q<=q-1.
  - q==0: wrap mode gives q<=MAX_VAL; saturate mode holds q.
- count=0: hold.
- Latency: q updates one clk after the qualifying inputs. No other pipelining.
- Terminal condition: term = inc ? (q==MAX_VAL) : (q==0).
- cout = reset_ & count & ~clr & ~load & term. Purely combinational, valid in the same cycle, asserted in both wrap and saturate modes. Drives the next stage's count, so ripple-enable cascading gives a correct multi-digit counter.
- zero and max are decoded combinationally from q.
- inc or sat changing mid-count takes effect on the next edge. No state beyond q.
- All arithmetic is done at WIDTH+1 bits to avoid overflow when MAX_VAL = 2**WIDTH-1.

Optional Feature:
- Macro: UPDOWN_COUNTER_STEP_EN.
- With the macro defined:
  - Extra input port step, WIDTH bits, gives a count step of step per enabled edge.
  - Up: if q+step > MAX_VAL, wrap gives q<=q+step-(MAX_VAL+1) and saturate gives q<=MAX_VAL.
  - Down: if step > q, wrap gives q<=q-step+(MAX_VAL+1) and saturate gives q<=0.
  - step > MAX_VAL is clamped to MAX_VAL.
  - step==0: q holds, cout=0.
  - cout asserts when the enabled step crosses or reaches the boundary, i.e. wrap or saturation occurs.
- Without the macro: no step port; step is fixed at 1, and behaviour is exactly as above.

Decomposition:
- Package updown_counter_pkg holds:
  - Direction constants DIR_UP=1'b1, DIR_DN=1'b0.
  - Mode constants MODE_WRAP=1'b0, MODE_SAT=1'b1.
  - A function computing default MAX_VAL from WIDTH.
- One natural sub-module: updown_counter_next. Purely combinational; computes the next q and term from q, inc, sat, step and MAX_VAL. The top holds the async-reset register, the priority mux and the flags.

Test Plan:
All cases use WIDTH=4, MAX_VAL=9 unless stated.
- Reset: drive reset_=0 mid-count at q=5, asynchronously between edges -> q=0 and zero=1 immediately. After release, count=1, inc=1 gives q=1 after the first edge.
- Wrap up/down:
  - sat=0, inc=1, start q=8, two edges -> q=9 (max=1, cout=1 during that cycle), then q=0.
  - inc=0 from q=0 -> cout=1, next q=9.
- Saturate: sat=1, inc=1 at q=9, 3 edges -> q stays 9, cout=1 each cycle. Same check for inc=0 at q=0 -> stays 0.
- Priority/clamp:
  - clr=1, load=1, load_val=7, count=1 at q=4 -> q=0.
  - Next, load=1, load_val=12 -> q=9.
  - load with count=1 -> cout=0.
- Cascade: two instances with MAX_VAL=9, low.cout -> high.count. Count 100 edges up from 00 -> reads 00 with high.cout pulse on edge 99. Down from 00 -> reads 99.
- Step (UPDOWN_COUNTER_STEP_EN): step=4, sat=0, up from q=7 -> q=1, cout=1. With sat=1 from q=7 -> q=9. step=0 -> q holds, cout=0.
